// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop process
// the operands LSB first, one bit per clock, behind start/ready and valid/ack.
module bit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c, last;

  always_comb begin
    fa_s = sa[0] ^ sb[0] ^ carry;
    fa_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    last = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    if (ack)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          // On the MSB slice, carry holds the carry into the MSB.
          if (last) begin
            ovf  <= carry ^ fa_c;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

endmodule
